// File: rtl/kc87_tap_recorder.sv
// kc87_tap_recorder: demodulates the KC87 FSK tape-out signal into
// checksummed records and serves them as a .TAP image over ioctl.
module kc87_tap_recorder #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int ADDR_W   = 16,
   parameter int LEAD_MIN = 200
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        tape_out,
   input  logic        tape_clear,
   input  logic        ioctl_upload,
   input  logic        ioctl_rd,
   input  logic [24:0] ioctl_addr,
   output logic [7:0]  ioctl_din,
   output logic [24:0] tap_len,
   output logic        rec_active,
   output logic        rec_err,
   output logic        buf_full
);

   // period thresholds in clk cycles (208 / 625 / 1250 / 2500 us)
   localparam logic [19:0] L_T0 =
      20'(64'(CLK_HZ) * 64'd208 / 64'd1_000_000);
   localparam logic [19:0] L_T1 =
      20'(64'(CLK_HZ) * 64'd625 / 64'd1_000_000);
   localparam logic [19:0] L_TS =
      20'(64'(CLK_HZ) * 64'd1250 / 64'd1_000_000);
   localparam logic [19:0] L_TX =
      20'(64'(CLK_HZ) * 64'd2500 / 64'd1_000_000);

   // buffer geometry: record footprint and total depth
   localparam logic [ADDR_W+1:0] L_REC   = (ADDR_W+2)'(129);
   localparam logic [ADDR_W+1:0] L_DEPTH = {2'b01, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_LEAD,
      S_BYTE
   } state_t;

   typedef enum logic [1:0] {
      SEL_ZERO,
      SEL_HDR,
      SEL_MEM
   } sel_t;

   logic [2:0]        r_sync;
   logic              r_edge;
   logic [19:0]       r_cnt;

   state_t            r_state;
   logic [15:0]       r_lead;
   logic [7:0]        r_idx;
   logic [3:0]        r_bits;
   logic [7:0]        r_shift;
   logic [7:0]        r_sum;
   logic [ADDR_W:0]   r_base;
   logic              r_drop;
   logic              r_err;
   logic              r_full;

   state_t            w_state_n;
   logic [15:0]       w_lead_n;
   logic [7:0]        w_idx_n;
   logic [3:0]        w_bits_n;
   logic [7:0]        w_shift_n;
   logic [7:0]        w_sum_n;
   logic [ADDR_W:0]   w_base_n;
   logic              w_drop_n;
   logic              w_err_n;
   logic              w_full_n;

   logic              w_c0;
   logic              w_c1;
   logic              w_cs;
   logic              w_cx;
   logic              w_nofit;

   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [7:0]        w_wdata;

   logic              w_rd;
   logic              w_hdr_hit;
   logic              w_mem_hit;
   logic [ADDR_W-1:0] w_raddr;

   logic [7:0]        r_mem [0:(2**ADDR_W)-1];
   logic [7:0]        r_rdq;
   sel_t              r_sel;
   logic [7:0]        r_hdr;

   // synchronise tape_out and register its rising edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= 3'b000;
         r_edge <= 1'b0;
      end else begin
         r_sync <= {r_sync[1:0], tape_out};
         r_edge <= r_sync[1] & ~r_sync[2];
      end
   end

   // edge-to-edge period counter; holds the period on the edge cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (r_edge) begin
         r_cnt <= 20'd1;
      end else if (r_cnt != '1) begin
         r_cnt <= r_cnt + 20'd1;
      end
   end

   assign w_c0 = r_edge && (r_cnt >= L_T0) && (r_cnt < L_T1);
   assign w_c1 = r_edge && (r_cnt >= L_T1) && (r_cnt < L_TS);
   assign w_cs = r_edge && (r_cnt >= L_TS) && (r_cnt < L_TX);
   assign w_cx = r_edge && !(w_c0 || w_c1 || w_cs);

   assign w_nofit = ({1'b0, r_base} + L_REC) > L_DEPTH;

   // decoder state and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_lead  <= '0;
         r_idx   <= '0;
         r_bits  <= '0;
         r_shift <= '0;
         r_sum   <= '0;
         r_base  <= '0;
         r_drop  <= 1'b0;
         r_err   <= 1'b0;
         r_full  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_lead  <= w_lead_n;
         r_idx   <= w_idx_n;
         r_bits  <= w_bits_n;
         r_shift <= w_shift_n;
         r_sum   <= w_sum_n;
         r_base  <= w_base_n;
         r_drop  <= w_drop_n;
         r_err   <= w_err_n;
         r_full  <= w_full_n;
      end
   end

   // next-state logic: lead detect, bit/byte framing, checksum, commit
   always_comb begin
      w_state_n = r_state;
      w_lead_n  = r_lead;
      w_idx_n   = r_idx;
      w_bits_n  = r_bits;
      w_shift_n = r_shift;
      w_sum_n   = r_sum;
      w_base_n  = r_base;
      w_drop_n  = r_drop;
      w_err_n   = r_err;
      w_full_n  = r_full;
      w_we      = 1'b0;
      w_waddr   = ADDR_W'(r_base + (ADDR_W+1)'(r_idx));
      w_wdata   = r_shift;

      unique case (r_state)
         S_IDLE: begin
            if (w_c1) begin
               if (r_lead == 16'(LEAD_MIN - 1)) begin
                  w_state_n = S_LEAD;
                  w_lead_n  = '0;
                  w_drop_n  = w_nofit;
               end else begin
                  w_lead_n = r_lead + 16'd1;
               end
            end else if (r_edge) begin
               w_lead_n = '0;
            end
         end
         S_LEAD: begin
            if (w_cs) begin
               w_state_n = S_BYTE;
               w_idx_n   = '0;
               w_bits_n  = '0;
               w_sum_n   = '0;
            end else if (w_c0 || w_cx) begin
               w_state_n = S_IDLE;
            end
         end
         S_BYTE: begin
            if (w_c0 || w_c1) begin
               if (r_bits == 4'd8) begin
                  w_state_n = S_IDLE;
                  w_err_n   = 1'b1;
               end else begin
                  w_shift_n = {w_c1, r_shift[7:1]};
                  w_bits_n  = r_bits + 4'd1;
               end
            end else if (w_cs) begin
               if (r_bits != 4'd8) begin
                  w_state_n = S_IDLE;
                  w_err_n   = 1'b1;
               end else if (r_idx == 8'd129) begin
                  w_state_n = S_IDLE;
                  if (r_shift != r_sum) begin
                     w_err_n = 1'b1;
                  end else if (r_drop) begin
                     w_err_n  = 1'b1;
                     w_full_n = 1'b1;
                  end else begin
                     w_base_n = r_base + (ADDR_W+1)'(129);
                  end
               end else begin
                  w_we     = !r_drop;
                  w_idx_n  = r_idx + 8'd1;
                  w_bits_n = '0;
                  if (r_idx != 8'd0) begin
                     w_sum_n = r_sum + r_shift;
                  end
               end
            end else if (w_cx) begin
               w_state_n = S_IDLE;
               w_err_n   = 1'b1;
            end
         end
         default: begin
            w_state_n = S_IDLE;
         end
      endcase

      if (tape_clear) begin
         w_state_n = S_IDLE;
         w_lead_n  = '0;
         w_base_n  = '0;
         w_err_n   = 1'b0;
         w_full_n  = 1'b0;
      end
   end

   assign w_rd      = ioctl_rd & ioctl_upload;
   assign w_hdr_hit = ioctl_addr < 25'd16;
   assign w_mem_hit = !w_hdr_hit && (ioctl_addr < tap_len);
   assign w_raddr   = ADDR_W'(ioctl_addr - 25'd16);

   // record buffer: decoder write port, upload read port
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
      if (w_rd) begin
         r_rdq <= r_mem[w_raddr];
      end
   end

   function automatic logic [7:0] f_hdr(input logic [3:0] a);
      logic [7:0] v;
      case (a)
         4'h0:    v = 8'hC3;
         4'h1:    v = 8'h4B;
         4'h2:    v = 8'h43;
         4'h3:    v = 8'h2D;
         4'h4:    v = 8'h54;
         4'h5:    v = 8'h41;
         4'h6:    v = 8'h50;
         4'h7:    v = 8'h45;
         4'h8:    v = 8'h20;
         4'h9:    v = 8'h62;
         4'hA:    v = 8'h79;
         4'hB:    v = 8'h20;
         4'hC:    v = 8'h41;
         4'hD:    v = 8'h46;
         4'hE:    v = 8'h2E;
         default: v = 8'h20;
      endcase
      return v;
   endfunction

   // latch the read source on each strobe so data holds between strobes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sel <= SEL_ZERO;
         r_hdr <= 8'h00;
      end else if (w_rd) begin
         r_hdr <= f_hdr(ioctl_addr[3:0]);
         if (w_hdr_hit) begin
            r_sel <= SEL_HDR;
         end else if (w_mem_hit) begin
            r_sel <= SEL_MEM;
         end else begin
            r_sel <= SEL_ZERO;
         end
      end
   end

   // read data mux
   always_comb begin
      ioctl_din = 8'h00;
      case (r_sel)
         SEL_HDR: ioctl_din = r_hdr;
         SEL_MEM: ioctl_din = r_rdq;
         default: ioctl_din = 8'h00;
      endcase
   end

   assign tap_len    = (r_base == '0) ? 25'd0 : 25'(r_base) + 25'd16;
   assign rec_active = (r_state != S_IDLE);
   assign rec_err    = r_err;
   assign buf_full   = r_full;

endmodule

// File: tb/tb_kc87_tap_recorder.sv
// Bench for kc87_tap_recorder: FSK records driven into a large and a
// small-buffer instance, checked against a record-level model.
`timescale 1ns/1ps
module tb_kc87_tap_recorder;

   localparam int HZ   = 10_000;
   localparam int LMIN = 20;
   localparam int P0   = 4;
   localparam int P1   = 8;
   localparam int PS   = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        tape_out;
   logic        tape_clear;
   logic        ioctl_upload;
   logic        ioctl_rd;
   logic [24:0] ioctl_addr;

   logic [7:0]  a_din;
   logic [24:0] a_len;
   logic        a_act;
   logic        a_err;
   logic        a_full;
   logic [7:0]  b_din;
   logic [24:0] b_len;
   logic        b_act;
   logic        b_err;
   logic        b_full;

   always #5 clk = ~clk;

   kc87_tap_recorder #(
      .CLK_HZ(HZ), .ADDR_W(16), .LEAD_MIN(LMIN)
   ) u_a (
      .clk(clk), .reset_n(reset_n), .tape_out(tape_out),
      .tape_clear(tape_clear), .ioctl_upload(ioctl_upload),
      .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
      .ioctl_din(a_din), .tap_len(a_len), .rec_active(a_act),
      .rec_err(a_err), .buf_full(a_full)
   );

   kc87_tap_recorder #(
      .CLK_HZ(HZ), .ADDR_W(8), .LEAD_MIN(LMIN)
   ) u_b (
      .clk(clk), .reset_n(reset_n), .tape_out(tape_out),
      .tape_clear(tape_clear), .ioctl_upload(ioctl_upload),
      .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
      .ioctl_din(b_din), .tap_len(b_len), .rec_active(b_act),
      .rec_err(b_err), .buf_full(b_full)
   );

   int         n_chk = 0;
   int         n_fail = 0;
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic       ea, fa, eb, fb;
   logic [7:0] dat[128];
   int         rq[$];
   logic       act_seen;
   string      hdr = "KC-TAPE by AF. ";

   task automatic tick();
      @(posedge clk);
      #1;
      act_seen = act_seen | a_act;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic period(input int n);
      tape_out = 1'b1;
      repeat (n / 2) tick();
      tape_out = 1'b0;
      repeat (n - n / 2) tick();
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) period(v[i] ? P1 : P0);
      period(PS);
   endtask

   task automatic close_tape();
      tape_out = 1'b1;
      repeat (2) tick();
      tape_out = 1'b0;
      repeat (40) tick();
   endtask

   task automatic send_lead(input int n);
      for (int i = 0; i < n; i++) period(P1);
   endtask

   task automatic send_record(input logic [7:0] blk,
                              input logic [7:0] cks);
      send_lead(24);
      period(PS);
      send_byte(blk);
      for (int i = 0; i < 128; i++) send_byte(dat[i]);
      send_byte(cks);
      close_tape();
   endtask

   function automatic logic [7:0] dsum();
      logic [7:0] s = 8'h00;
      foreach (dat[i]) s = s + dat[i];
      return s;
   endfunction

   task automatic model_record(input logic [7:0] blk,
                               input logic [7:0] cks);
      if (cks != dsum()) begin
         ea = 1'b1;
         eb = 1'b1;
      end else begin
         if (qa.size() + 129 <= 65536) begin
            qa.push_back(blk);
            foreach (dat[i]) qa.push_back(dat[i]);
         end else begin
            ea = 1'b1;
            fa = 1'b1;
         end
         if (qb.size() + 129 <= 256) begin
            qb.push_back(blk);
            foreach (dat[i]) qb.push_back(dat[i]);
         end else begin
            eb = 1'b1;
            fb = 1'b1;
         end
      end
   endtask

   function automatic logic [24:0] mlen(input int n);
      return (n == 0) ? 25'd0 : 25'(n + 16);
   endfunction

   function automatic logic [7:0] mbyte_a(input int a);
      if (a == 0) return 8'hC3;
      if (a < 16) return 8'(hdr[a - 1]);
      if (a < int'(mlen(qa.size()))) return qa[a - 16];
      return 8'h00;
   endfunction

   task automatic do_reads(input string tag);
      ioctl_upload = 1'b1;
      for (int i = 0; i < rq.size(); i++) begin
         ioctl_rd   = 1'b1;
         ioctl_addr = 25'(rq[i]);
         tick();
         chk($sformatf("%s_rd%0d", tag, rq[i]), 32'(a_din),
             32'(mbyte_a(rq[i])));
      end
      ioctl_rd = 1'b0;
      repeat (3) tick();
      chk({tag, "_hold"}, 32'(a_din),
          32'(mbyte_a(rq[rq.size() - 1])));
      ioctl_upload = 1'b0;
   endtask

   task automatic do_clear();
      tape_clear = 1'b1;
      tick();
      tape_clear = 1'b0;
      tick();
      qa.delete();
      qb.delete();
      ea = 1'b0; fa = 1'b0; eb = 1'b0; fb = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      tape_out = 1'b0;
      tape_clear = 1'b0;
      ioctl_upload = 1'b0;
      ioctl_rd = 1'b0;
      ioctl_addr = '0;
      act_seen = 1'b0;
      ea = 1'b0; fa = 1'b0; eb = 1'b0; fb = 1'b0;
      repeat (3) tick();
      chk("rst_din", 32'(a_din), 32'h0);
      chk("rst_len", 32'(a_len), 32'h0);
      chk("rst_act", 32'(a_act), 32'h0);
      chk("rst_err", 32'(a_err), 32'h0);
      chk("rst_full", 32'(a_full), 32'h0);
      chk("rst_len_b", 32'(b_len), 32'h0);
      reset_n = 1'b1;
      repeat (50) tick();

      // nominal record: block 1, data 0..127
      foreach (dat[i]) dat[i] = 8'(i);
      send_record(8'h01, dsum());
      model_record(8'h01, dsum());
      chk("nom_len", 32'(a_len), 32'(mlen(qa.size())));
      chk("nom_len145", 32'(a_len), 32'd145);
      chk("nom_err", 32'(a_err), 32'(ea));
      chk("nom_len_b", 32'(b_len), 32'(mlen(qb.size())));
      chk("nom_full_b", 32'(b_full), 32'(fb));
      rq.delete();
      for (int a = 0; a < 16; a++) rq.push_back(a);
      rq.push_back(16);
      rq.push_back(17);
      rq.push_back(144);
      rq.push_back(145);
      do_reads("nom");

      // second record, uploaded back-to-back while it decodes
      foreach (dat[i]) dat[i] = 8'($urandom);
      rq.delete();
      for (int a = 0; a < 152; a++) rq.push_back(a);
      rq.push_back(200);
      fork
         send_record(8'h02, dsum());
         begin
            repeat (600) tick();
            do_reads("upl");
         end
      join
      model_record(8'h02, dsum());
      chk("r2_len", 32'(a_len), 32'(mlen(qa.size())));
      chk("r2_err", 32'(a_err), 32'(ea));
      chk("r2_act", 32'(a_act), 32'h0);
      chk("ovf_len_b", 32'(b_len), 32'(mlen(qb.size())));
      chk("ovf_full_b", 32'(b_full), 32'(fb));
      chk("ovf_err_b", 32'(b_err), 32'(eb));
      rq.delete();
      for (int i = 0; i < 8; i++) rq.push_back(145 + $urandom_range(0, 128));
      rq.push_back(273);
      rq.push_back(274);
      do_reads("r2");

      // clear while upload is active
      ioctl_upload = 1'b1;
      do_clear();
      ioctl_upload = 1'b0;
      chk("clr_len", 32'(a_len), 32'(mlen(qa.size())));
      chk("clr_len_b", 32'(b_len), 32'(mlen(qb.size())));
      chk("clr_full_b", 32'(b_full), 32'(fb));
      chk("clr_err_b", 32'(b_err), 32'(eb));

      // bad checksum, then a valid record
      foreach (dat[i]) dat[i] = 8'($urandom);
      send_record(8'h03, dsum() + 8'h01);
      model_record(8'h03, dsum() + 8'h01);
      chk("bad_len", 32'(a_len), 32'(mlen(qa.size())));
      chk("bad_err", 32'(a_err), 32'(ea));
      foreach (dat[i]) dat[i] = 8'($urandom);
      send_record(8'h04, dsum());
      model_record(8'h04, dsum());
      chk("aft_bad_len", 32'(a_len), 32'(mlen(qa.size())));
      chk("aft_bad_err", 32'(a_err), 32'(ea));
      rq.delete();
      for (int a = 14; a < 147; a++) rq.push_back(a);
      do_reads("aft_bad");

      // framing error: separator after five bits
      do_clear();
      send_lead(24);
      period(PS);
      for (int i = 0; i < 5; i++)
         period($urandom_range(0, 1) != 0 ? P1 : P0);
      period(PS);
      close_tape();
      ea = 1'b1;
      chk("frm_err", 32'(a_err), 32'(ea));
      chk("frm_act", 32'(a_act), 32'h0);
      chk("frm_len", 32'(a_len), 32'(mlen(qa.size())));
      foreach (dat[i]) dat[i] = 8'($urandom);
      send_record(8'h05, dsum());
      model_record(8'h05, dsum());
      chk("aft_frm_len", 32'(a_len), 32'(mlen(qa.size())));
      rq.delete();
      for (int a = 16; a < 21; a++) rq.push_back(a);
      rq.push_back(144);
      rq.push_back(145);
      do_reads("aft_frm");

      // short lead must never start a record
      do_clear();
      act_seen = 1'b0;
      send_lead(LMIN - 5);
      period(PS);
      period(P0);
      close_tape();
      chk("short_seen", 32'(act_seen), 32'h0);
      chk("short_act", 32'(a_act), 32'h0);
      chk("short_err", 32'(a_err), 32'(ea));
      chk("short_len", 32'(a_len), 32'(mlen(qa.size())));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
